// File: rtl/whack_pkg.sv
// Shared types and helpers for the hit-or-miss round sequencer.
package whack_pkg;
    localparam int LED_W = 8;
    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        SHOW = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] hits;
        logic [7:0] misses;
        logic [7:0] round_idx;
    } tally_t;

    function automatic logic is_onehot(input logic [LED_W-1:0] v);
        return (v != '0) && ((v & (v - LED_W'(1))) == '0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/switch_edge.sv
// Two-flop synchronizer on the raw switches plus a previous-sample register;
// toggled flags bits that changed between the last two synchronized samples.
module switch_edge
    import whack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] switch,
    output logic [LED_W-1:0] toggled
);
    logic [LED_W-1:0] sync1, sync2, prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign toggled = sync2 ^ prev;
endmodule

// File: rtl/whack_round_ctrl.sv
// Round sequencer: fetch a one-hot target, light it for a window, judge the
// first toggle as hit/miss, pause, and tally over a fixed number of rounds.
module whack_round_ctrl
    import whack_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 100_000_000,
    parameter int unsigned GAP_CYCLES    = 25_000_000,
    parameter int unsigned ROUNDS        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             rand_req,
    input  logic             rand_valid,
    input  logic [LED_W-1:0] rand_led,
    input  logic [LED_W-1:0] switch,
    output logic [LED_W-1:0] led,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic [7:0]       hits,
    output logic [7:0]       misses,
    output logic [7:0]       round_idx,
    output logic             busy,
    output logic             done
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [LED_W-1:0] target;
    logic [LED_W-1:0] toggled;
    tally_t           tally;

    switch_edge u_switch_edge (
        .clk     (clk),
        .rst     (rst),
        .switch  (switch),
        .toggled (toggled)
    );

    // A toggle wins over a timeout landing on the same edge.
    logic window_end, verdict, is_hit;
    assign window_end = (cnt == CNT_W'(WINDOW_CYCLES - 1));
    assign verdict    = (toggled != '0) || window_end;
    assign is_hit     = (toggled == target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            target     <= '0;
            tally      <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        tally <= '0;
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (rand_valid && is_onehot(rand_led)) begin
                        target <= rand_led;
                        cnt    <= '0;
                        state  <= SHOW;
                    end
                end
                SHOW: begin
                    if (verdict) begin
                        if (is_hit) begin
                            hit_pulse  <= 1'b1;
                            tally.hits <= sat_inc(tally.hits);
                        end else begin
                            miss_pulse   <= 1'b1;
                            tally.misses <= sat_inc(tally.misses);
                        end
                        tally.round_idx <= tally.round_idx + 8'd1;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= (tally.round_idx == 8'(ROUNDS)) ? DONE : ARM;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign led       = (state == SHOW) ? target : '0;
    assign rand_req  = (state == ARM);
    assign busy      = (state == ARM) || (state == SHOW) || (state == GAP);
    assign done      = (state == DONE);
    assign hits      = tally.hits;
    assign misses    = tally.misses;
    assign round_idx = tally.round_idx;
endmodule

// File: doc/whack_round_ctrl.md
# whack_round_ctrl

Round sequencer for the hit-or-miss game. It requests a one-hot LED from the randomizer and lights it for a fixed window. It judges the first switch toggle during that window as a hit or a miss, then runs a blank gap before the next round. It also keeps the hit and miss tallies over a fixed number of rounds and sits between the randomizer, the board switches/LEDs and the score display.

## Interface
Parameters:
- WINDOW_CYCLES, 100_000_000, clk cycles the target LED stays lit (1 s at 100 MHz)
- GAP_CYCLES, 25_000_000, clk cycles of all-LEDs-off between rounds
- ROUNDS, 16, rounds per game (1..255)

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a game
- rand_req  out  1  request to randomizer
- rand_valid  in  1  rand_led valid this cycle
- rand_led  in  8  candidate LED pattern
- switch  in  8  raw asynchronous board switches
- led  out  8  LED drive, one-hot in SHOW, else 0
- hit_pulse  out  1  one-cycle hit verdict
- miss_pulse  out  1  one-cycle miss verdict
- hits  out  8  hit count, saturating
- misses  out  8  miss count, saturating
- round_idx  out  8  rounds completed this game
- busy  out  1  game in progress (not IDLE/DONE)
- done  out  1  high in DONE

## Operation
- States: IDLE, ARM, SHOW, GAP, DONE.
- IDLE:
  - start → ARM.
  - Clears hits, misses and round_idx on the transition.
- ARM:
  - rand_req high, held until rand_valid.
  - If rand_valid and rand_led is one-hot, latch target = rand_led → SHOW.
  - If rand_valid and rand_led is zero or multi-bit, discard it and keep rand_req high.
- SHOW:
  - led = target; the window counter counts up from 0.
  - toggled = synchronized switch XOR its previous sample.
  - toggled == target → hit.
  - toggled != 0 and toggled != target → miss. This includes the correct bit toggling together with any other bit.
  - No toggle by count WINDOW_CYCLES-1 → miss (timeout).
  - A verdict clears led, pulses hit_pulse or miss_pulse, increments the matching tally (saturating at 255) and round_idx → GAP.
- GAP:
  - led = 0; toggles are ignored.
  - After GAP_CYCLES cycles: round_idx == ROUNDS → DONE, else → ARM.
- DONE:
  - Tallies frozen, done = 1.
  - start → clear tallies and round_idx → ARM.
- start in ARM, SHOW or GAP is ignored.
- Switch toggles outside SHOW are never counted. This covers synchronizer warm-up after reset.
- Reset mid-operation:
  - Every output and all state are zeroed: led, rand_req, pulses, hits, misses, round_idx, busy, done = 0.
  - The FSM returns to IDLE and the synchronizer and previous-sample flops are cleared.

## Timing
- start sampled at edge N → rand_req = 1 after edge N.
- Accepted rand_valid at edge M → led = target after edge M; SHOW counter = 0 in that cycle.
- A switch change first sampled by the sync flop at edge k → verdict pulse and led = 0 after edge k+2.
  - The path is a 2-flop synchronizer followed by a previous-sample register.
- With no toggle, the miss pulse is visible after the WINDOW_CYCLES-th edge in SHOW, so led is lit for exactly WINDOW_CYCLES cycles.
- Pulses last exactly one cycle; hit_pulse and miss_pulse are never both high.
- The tallies and round_idx update on the same edge as the pulse.
- GAP lasts exactly GAP_CYCLES cycles.
- Counters are 32-bit, wide enough for both cycle parameters.

## Structure
- Package whack_pkg: state enum (IDLE, ARM, SHOW, GAP, DONE), LED_W = 8, CNT_W = 32, and an is_onehot function.
- Sub-module switch_edge:
  - 2-flop synchronizer plus previous-sample register.
  - Outputs toggled[7:0].
  - Asynchronous reset clears all flops.
- The top module holds the FSM, the window/gap counter, the target register and the tallies.

## Test plan
All scenarios use WINDOW_CYCLES=20, GAP_CYCLES=5, ROUNDS=3.
- Happy path:
  - Stimulus: start; randomizer returns 8'h04; switch[2] flips 5 cycles into SHOW.
  - Required: hit_pulse after sync latency, led=0, hits=1, round_idx=1, then 5 cycles of led=0 and rand_req reasserted.
- Invalid random:
  - Stimulus: rand_led 8'h00, then 8'h81, then 8'h10.
  - Required: the first two are rejected with rand_req held high; led=8'h10 after the third.
- Wrong or simultaneous toggle:
  - Stimulus: target 8'h01; switch[3] flips; next round, target 8'h01 and switch[0] and switch[1] flip on the same cycle.
  - Required: miss_pulse both times, misses=2.
- Timeout:
  - Stimulus: target 8'h08, no toggle.
  - Required: led=8'h08 for exactly 20 cycles, then miss_pulse.
- Full game and restart:
  - Stimulus: 3 rounds.
  - Required: done=1, busy=0 and round_idx=3 are held; start in DONE clears hits, misses and round_idx to 0 and rand_req rises. start during SHOW has no effect.
- Reset mid-SHOW:
  - Stimulus: assert rst during SHOW.
  - Required: all outputs 0 immediately; IDLE; a toggle after reset and before start produces no pulse.
